// File: rtl/jt10_adpcm_mix.sv
// jt10_adpcm_mix
// Sums the six attenuated ADPCM-A channels into left/right accumulators over
// one slot rotation, then saturates the totals to 16 bits and presents a
// stereo sample together with a one-clk strobe and per-side clip flags.
module jt10_adpcm_mix (
   input  logic               clk,
   input  logic               rst,
   input  logic               cen,
   input  logic [5:0]         cur_ch,
   input  logic [5:0]         en_ch,
   input  logic [1:0]         lr,
   input  logic signed [15:0] pcm_att,
   output logic signed [15:0] pcm_l,
   output logic signed [15:0] pcm_r,
   output logic               sample_stb,
   output logic               clip_l,
   output logic               clip_r
);

   // Output range of a 16-bit signed sample, expressed at accumulator width
   localparam logic signed [18:0] MAX16 = 19'sd32767;
   localparam logic signed [18:0] MIN16 = -19'sd32768;

   // UNPRIMED blocks output until a full round starting at slot 0 is seen
   typedef enum logic {
      UNPRIMED,
      PRIMED
   } state_t;

   state_t state;
   state_t next_state;

   logic               out_en;
   logic               slot_valid;
   logic               act;
   logic               round_start;
   logic               round_end;
   logic signed [18:0] pcm_ext;
   logic signed [18:0] add_l;
   logic signed [18:0] add_r;
   logic signed [18:0] acc_l;
   logic signed [18:0] acc_r;
   logic signed [18:0] sum_l;
   logic signed [18:0] sum_r;
   logic signed [15:0] sat_l;
   logic signed [15:0] sat_r;
   logic               over_l;
   logic               over_r;

   // Clamp a 19-bit sum into the 16-bit signed range
   function automatic logic signed [15:0] sat16(input logic signed [18:0] v);
      logic signed [15:0] r;
      if (v > MAX16) begin
         r = 16'sh7FFF;
      end else if (v < MIN16) begin
         r = 16'sh8000;
      end else begin
         r = v[15:0];
      end
      return r;
   endfunction

   // A slot only counts when cur_ch carries exactly one bit; anything else is ignored
   always_comb begin
      slot_valid  = (cur_ch != 6'd0) && ((cur_ch & (cur_ch - 6'd1)) == 6'd0);
      act         = slot_valid && (|(cur_ch & en_ch));
      round_start = slot_valid && cur_ch[0];
      round_end   = slot_valid && cur_ch[5];
   end

   // Per-slot contributions after channel enable and panning
   always_comb begin
      pcm_ext = {{3{pcm_att[15]}}, pcm_att};
      add_l   = (act && lr[1]) ? pcm_ext : 19'sd0;
      add_r   = (act && lr[0]) ? pcm_ext : 19'sd0;
      sum_l   = acc_l + add_l;
      sum_r   = acc_r + add_r;
   end

   // Saturation and clip detection on the round totals
   always_comb begin
      sat_l  = sat16(sum_l);
      sat_r  = sat16(sum_r);
      over_l = (sum_l > MAX16) || (sum_l < MIN16);
      over_r = (sum_r > MAX16) || (sum_r < MIN16);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= UNPRIMED;
      end else begin
         state <= next_state;
      end
   end

   // FSM next state: the first valid slot 0 arms the output path
   always_comb begin
      next_state = state;
      case (state)
         UNPRIMED: if (cen && round_start) next_state = PRIMED;
         PRIMED:   next_state = PRIMED;
         default:  next_state = UNPRIMED;
      endcase
   end

   // FSM output decode: results are only published once primed
   always_comb begin
      out_en = (state == PRIMED);
   end

   // Accumulate the round, restart on slot 0, publish and clear on slot 5
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_l      <= 19'sd0;
         acc_r      <= 19'sd0;
         pcm_l      <= 16'sd0;
         pcm_r      <= 16'sd0;
         clip_l     <= 1'b0;
         clip_r     <= 1'b0;
         sample_stb <= 1'b0;
      end else begin
         sample_stb <= 1'b0;
         if (cen && slot_valid) begin
            if (round_start) begin
               acc_l <= add_l;
               acc_r <= add_r;
            end else if (round_end) begin
               acc_l <= 19'sd0;
               acc_r <= 19'sd0;
               if (out_en) begin
                  pcm_l      <= sat_l;
                  pcm_r      <= sat_r;
                  clip_l     <= over_l;
                  clip_r     <= over_r;
                  sample_stb <= 1'b1;
               end
            end else begin
               acc_l <= sum_l;
               acc_r <= sum_r;
            end
         end
      end
   end

endmodule

// File: tb/tb_jt10_adpcm_mix.sv
// tb_jt10_adpcm_mix
// Directed bench for the ADPCM-A stereo mixer with hand-computed results.
module tb_jt10_adpcm_mix;

   logic               clk;
   logic               rst;
   logic               cen;
   logic [5:0]         cur_ch;
   logic [5:0]         en_ch;
   logic [1:0]         lr;
   logic signed [15:0] pcm_att;
   logic signed [15:0] pcm_l;
   logic signed [15:0] pcm_r;
   logic               sample_stb;
   logic               clip_l;
   logic               clip_r;

   int                 checksTotal;
   int                 checksPassed;
   int                 checksFailed;
   logic               stbAfter;
   int                 pcmVec [6];
   logic [1:0]         lrVec  [6];

   jt10_adpcm_mix dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .cur_ch     (cur_ch),
      .en_ch      (en_ch),
      .lr         (lr),
      .pcm_att    (pcm_att),
      .pcm_l      (pcm_l),
      .pcm_r      (pcm_r),
      .sample_stb (sample_stb),
      .clip_l     (clip_l),
      .clip_r     (clip_r)
   );

   // Free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value against its expected value
   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checksTotal++;
      assert (observed === expected) checksPassed++;
      else begin
         checksFailed++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Present one slot for a single cen-qualified edge, then drop cen
   task automatic applyStimulus(input logic [5:0] ch, input int pcm, input logic [1:0] l);
      @(negedge clk);
      cur_ch  = ch;
      pcm_att = pcm[15:0];
      lr      = l;
      cen     = 1'b1;
      @(negedge clk);
      stbAfter = sample_stb;
      cen      = 1'b0;
   endtask

   // Run slots lo..hi from the round vectors
   task automatic applySlots(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         applyStimulus(6'b000001 << i, pcmVec[i], lrVec[i]);
      end
   endtask

   // Fill the round vectors with one value and one pan setting
   task automatic setRound(input int p, input logic [1:0] l);
      for (int i = 0; i < 6; i++) begin
         pcmVec[i] = p;
         lrVec[i]  = l;
      end
   endtask

   // Check the published sample right after a slot-5 edge and the strobe width
   task automatic checkRound(input string tag, input int expL, input int expR,
                             input logic expClipL, input logic expClipR);
      checkOutput({tag, "_stb"}, stbAfter, 1);
      checkOutput({tag, "_pcm_l"}, pcm_l, expL);
      checkOutput({tag, "_pcm_r"}, pcm_r, expR);
      checkOutput({tag, "_clip_l"}, clip_l, expClipL);
      checkOutput({tag, "_clip_r"}, clip_r, expClipR);
      @(negedge clk);
      checkOutput({tag, "_stb_width"}, sample_stb, 0);
   endtask

   initial begin
      checksTotal  = 0;
      checksPassed = 0;
      checksFailed = 0;
      stbAfter     = 1'b0;
      rst          = 1'b1;
      cen          = 1'b0;
      cur_ch       = 6'd0;
      en_ch        = 6'h3F;
      lr           = 2'b00;
      pcm_att      = 16'sd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset values
      checkOutput("reset_pcm_l", pcm_l, 0);
      checkOutput("reset_pcm_r", pcm_r, 0);
      checkOutput("reset_stb", sample_stb, 0);
      checkOutput("reset_clip_l", clip_l, 0);
      checkOutput("reset_clip_r", clip_r, 0);

      // Reset in the middle of a round at slot 3, then finish the partial round
      setRound(100, 2'b11);
      applySlots(0, 2);
      @(negedge clk);
      rst     = 1'b1;
      cen     = 1'b1;
      cur_ch  = 6'b001000;
      pcm_att = 16'sd100;
      @(negedge clk);
      rst = 1'b0;
      cen = 1'b0;
      applySlots(4, 5);
      checkOutput("unprimed_stb", stbAfter, 0);
      checkOutput("unprimed_pcm_l", pcm_l, 0);
      checkOutput("unprimed_pcm_r", pcm_r, 0);
      applySlots(0, 5);
      checkRound("prime", 600, 600, 1'b0, 1'b0);

      // Panning alternating left/right
      for (int i = 0; i < 6; i++) begin
         pcmVec[i] = 1000;
         lrVec[i]  = (i % 2 == 0) ? 2'b10 : 2'b01;
      end
      applySlots(0, 5);
      checkRound("pan_alt", 3000, 3000, 1'b0, 1'b0);

      // Left only, so a swapped side shows up
      setRound(100, 2'b10);
      applySlots(0, 5);
      checkRound("pan_left", 600, 0, 1'b0, 1'b0);

      // Muted pan
      setRound(1000, 2'b00);
      applySlots(0, 5);
      checkRound("pan_mute", 0, 0, 1'b0, 1'b0);

      // Enable mask keeps channels 0 and 2
      en_ch = 6'b000101;
      setRound(-2000, 2'b11);
      applySlots(0, 5);
      checkRound("en_mask", -4000, -4000, 1'b0, 1'b0);
      en_ch = 6'h3F;

      // Positive saturation
      setRound(20000, 2'b11);
      applySlots(0, 5);
      checkRound("sat_pos", 32767, 32767, 1'b1, 1'b1);

      // Negative saturation
      setRound(-32768, 2'b11);
      applySlots(0, 5);
      checkRound("sat_neg", -32768, -32768, 1'b1, 1'b1);

      // Small total clears the clip flags
      setRound(0, 2'b11);
      pcmVec[0] = 5;
      applySlots(0, 5);
      checkRound("small", 5, 5, 1'b0, 1'b0);

      // Outputs hold while the next round is still accumulating
      setRound(1234, 2'b11);
      applySlots(0, 3);
      checkOutput("hold_pcm_l", pcm_l, 5);
      checkOutput("hold_stb", stbAfter, 0);
      applySlots(4, 5);
      checkRound("hold_end", 7404, 7404, 1'b0, 1'b0);

      // Ungated reference round
      for (int i = 0; i < 6; i++) begin
         pcmVec[i] = 10 * (i + 1);
         lrVec[i]  = 2'b11;
      end
      applySlots(0, 5);
      checkRound("ungated", 210, 210, 1'b0, 1'b0);

      // Same round with a seven-clk cen gap between slots 2 and 3
      applySlots(0, 2);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         cen     = 1'b0;
         cur_ch  = 6'b100000;
         lr      = 2'b11;
         pcm_att = 16'($urandom);
         checkOutput("gap_stb", sample_stb, 0);
      end
      checkOutput("gap_hold_pcm_l", pcm_l, 210);
      applySlots(3, 5);
      checkRound("gated", 210, 210, 1'b0, 1'b0);

      // Non-one-hot slot inside a round contributes nothing
      setRound(1, 2'b11);
      applySlots(0, 2);
      applyStimulus(6'b000011, 7777, 2'b11);
      applySlots(3, 5);
      checkRound("invalid_slot", 6, 6, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", checksPassed, checksTotal);
      $finish;
   end

endmodule
